// File: rtl/p2_mem_write.sv
// Write-side address/enable generator for the pooling-2 output memory.
// Accepts a valid/ready sample stream and writes N_CH x N_PIX words in channel-major order.
module p2_mem_write #(
    parameter int DATA_W = 16,
    parameter int N_CH   = 12,
    parameter int N_PIX  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       hold,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       wr_en,
    output logic [3:0]                 wr_ch,
    output logic [$clog2(N_PIX)-1:0]   wr_addr,
    output logic [DATA_W-1:0]          wr_data,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(N_PIX);

    // Handshake: a sample transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state and hold, never on in_valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        LAST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [3:0]      ch_cnt;
    logic [AW-1:0]   pix_cnt;
    logic            accept;
    logic            last_smp;
    logic            clr_cnt;

    assign accept   = in_valid && in_ready;
    assign last_smp = (ch_cnt == 4'(N_CH - 1)) && (pix_cnt == AW'(N_PIX - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        clr_cnt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = WRITE;
                    clr_cnt  = 1'b1;
                end
            end
            WRITE: begin
                busy     = 1'b1;
                in_ready = !hold;
                if (in_valid && !hold && last_smp) begin
                    state_nx = LAST;
                end
            end
            LAST: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_nx = WRITE;
                    clr_cnt  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Channel counter saturates at N_CH-1 so the final wrap cannot overflow it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_cnt  <= '0;
            pix_cnt <= '0;
        end else if (clr_cnt) begin
            ch_cnt  <= '0;
            pix_cnt <= '0;
        end else if (accept) begin
            if (pix_cnt == AW'(N_PIX - 1)) begin
                pix_cnt <= '0;
                if (ch_cnt != 4'(N_CH - 1)) begin
                    ch_cnt <= ch_cnt + 4'd1;
                end
            end else begin
                pix_cnt <= pix_cnt + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_ch   <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_ch   <= ch_cnt;
                wr_addr <= pix_cnt;
                wr_data <= in_data;
            end
        end
    end

endmodule

// File: doc/p2_mem_write.md
# p2_mem_write

Write-side address/enable generator for the pooling-2 output memory. It accepts the pooled result stream from the pooling-2 datapath over a valid/ready handshake and writes the 12 channels × 16 pixels (4×4 per channel) in channel-major order. That order is channel 0 addresses 0..15, then channel 1, and so on up to channel 11. This is the same order in which the pooling-2 read counter later walks the memory. When the final word is committed, the block raises `done` so the read side can be enabled.

## Interface
- `DATA_W`, default 16: width of one pooled sample.
- `N_CH`, default 12: number of channels per frame.
- `N_PIX`, default 16: pixels per channel (4×4). Must be a power of two.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  single-cycle pulse that begins a frame. Honoured only in IDLE or DONE.
- `hold`  in  1  reader owns the memory. While high, `in_ready` is forced low.
- `in_valid`  in  1  `in_data` is valid.
- `in_data`  in  `DATA_W`  pooled sample.
- `in_ready`  out  1  sample is accepted on a cycle where `in_valid && in_ready`.
- `wr_en`  out  1  memory write strobe, one cycle per accepted sample.
- `wr_ch`  out  4  channel (bank) of the write, 0..`N_CH`-1.
- `wr_addr`  out  `$clog2(N_PIX)`  pixel address within the channel, 0..`N_PIX`-1.
- `wr_data`  out  `DATA_W`  registered copy of the accepted `in_data`.
- `busy`  out  1  high in the WRITE and LAST states.
- `done`  out  1  level signal. High in the DONE state until the next `start` or `reset`.

## Operation
- States:
  - IDLE: after reset. `in_ready`=0. `start` moves to WRITE.
  - WRITE: `in_ready` = !`hold`. Each acceptance issues one write and advances the counters.
  - LAST: entered on acceptance of sample (`N_CH`-1, `N_PIX`-1). The final `wr_en` is issued this cycle and `in_ready`=0. Always moves to DONE next.
  - DONE: `done`=1 and `in_ready`=0. `start` moves to WRITE.
- On WRITE entry, the pixel counter and the channel counter are both cleared to 0.
- On acceptance:
  - The pixel counter increments.
  - At `N_PIX`-1 the pixel counter wraps to 0 and the channel counter increments.
  - The channel counter never exceeds `N_CH`-1.
- Writes:
  - `wr_ch`, `wr_addr` and `wr_data` are registered with the pre-increment counter values of the accepted sample.
  - `wr_en` pulses for exactly one cycle per acceptance.
  - Exactly `N_CH`×`N_PIX` (192) writes are issued per frame. There are no skips and no duplicates.
- Ignored inputs:
  - `start` in WRITE or LAST is ignored. The frame is not restarted.
  - `in_valid` outside WRITE is ignored. No write occurs and no counter moves.
- `hold` is sampled combinationally into `in_ready`. A sample presented while `hold`=1 stays pending until `hold` falls. The upstream must keep `in_data` stable while `in_valid && !in_ready`.
- Reset is asynchronous and may occur mid-frame. All of the following go to 0 immediately: state (IDLE), counters, `wr_en`, `wr_ch`, `wr_addr`, `wr_data`, `in_ready`, `busy`, `done`. The partially written frame is abandoned.

## Timing
- `start` is sampled at edge 0. WRITE begins in cycle 1, and `in_ready` can be high in cycle 1.
- Write latency:
  - A sample accepted at edge k produces `wr_en`=1 during cycle k+1, carrying that sample's ch/addr/data.
  - With `in_valid` and `in_ready` continuously high, the block sustains one write per cycle.
- End of frame:
  - The last acceptance at edge n produces the final `wr_en` in cycle n+1 (state LAST).
  - `done` rises in cycle n+2, so the write is committed before the reader is enabled.
  - `busy` falls in the same cycle that `done` rises.
- `start` in DONE at edge m produces `done`=0 and WRITE in cycle m+1, with counters at 0.

## Test plan
- Reset, then `start`, then 192 back-to-back valid samples with data = index. Required: 192 `wr_en` pulses with (ch, addr) running (0,0)..(0,15),(1,0)..(11,15). `wr_data` must equal the index. `done` rises 2 cycles after the last acceptance.
- Throttle `in_valid` randomly at 50%. Required: the write sequence is identical to the previous test, with no gaps in addresses and `wr_en` count = 192.
- Drive `hold`=1 for 5 cycles while addr=7 of ch=3 is pending. Required: `in_ready`=0 and no `wr_en` for those 5 cycles. After `hold` falls, the write at (3,7) occurs once.
- Assert reset at ch=5, addr=9. Required: all outputs 0 immediately and state IDLE. A following `start` begins again at (0,0).
- Pulse `start` mid-frame at ch=2. Required: ignored, and the sequence continues. Drive `in_valid`=1 in DONE. Required: no `wr_en`. Pulse `start` in DONE. Required: `done` clears next cycle and a new frame begins at (0,0).
